fft32_sdf_ctrl: RTL and testbench

Sequencing controller for the 32-point radix-2 DIF single-path delay-feedback (SDF) FFT pipeline. It counts incoming samples into 32-sample frames and tracks each sample through the five stages, whose delay lines are 16, 8, 4, 2 and 1 deep. From that tracking it drives every stage's butterfly/bypass select and the twiddle ROM addresses for stages 0-3. It also reports output validity and the bit-reversed output index. The block contains no datapath; it sits beside the delay-line stages and the twiddle ROM.

---
 rtl/fft32_sdf_ctrl.sv | 101 ++++++++++
 tb/tb_fft32_sdf_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft32_sdf_ctrl.sv
// Sequencing controller for a 32-point radix-2 DIF SDF FFT: frames incoming samples,
// tracks each one through the five delay-feedback stages and derives selects, twiddles and output index.
module fft32_sdf_ctrl #(
  parameter int N_STAGE = 5,
  parameter int STG_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic [N_STAGE-1:0]         stage_sel,
  output logic [N_STAGE-2:0]         tw_en,
  output logic [4*(N_STAGE-1)-1:0]   tw_addr,
  output logic                       out_valid,
  output logic [N_STAGE-1:0]         out_idx,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic                       busy
);

  localparam int FW = N_STAGE - 1;

  function automatic int dly(input int s);
    return (1 << N_STAGE) >> (s + 1);
  endfunction

  function automatic int off(input int s);
    int o;
    o = 0;
    for (int j = 0; j < s; j++) o += dly(j) + STG_LAT;
    return o;
  endfunction

  localparam int DEPTH = off(N_STAGE - 1) + dly(N_STAGE - 1) + 1;

  logic [N_STAGE-1:0] cnt_reg;
  logic               err_reg;
  logic [DEPTH:1]     trk_v_reg;
  logic [N_STAGE-1:0] trk_c_reg [1:DEPTH];
  logic               abort;

  // A gap is only legal on a frame boundary; anywhere else it kills everything in flight.
  assign abort = ~in_valid & (cnt_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      trk_v_reg <= '0;
    end else begin
      err_reg <= abort;
      if (abort) begin
        cnt_reg   <= '0;
        trk_v_reg <= '0;
      end else begin
        if (in_valid) cnt_reg <= cnt_reg + 1'b1;
        trk_v_reg <= {trk_v_reg[DEPTH-1:1], in_valid};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= DEPTH; i++) trk_c_reg[i] <= '0;
    end else begin
      trk_c_reg[1] <= cnt_reg;
      for (int i = 2; i <= DEPTH; i++) trk_c_reg[i] <= trk_c_reg[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_STAGE; gi++) begin : g_sel
      localparam int OFF = off(gi);
      if (OFF == 0) begin : g_tap0
        assign stage_sel[gi] = in_valid & cnt_reg[N_STAGE-1-gi];
      end else begin : g_tapk
        assign stage_sel[gi] = trk_v_reg[OFF] & trk_c_reg[OFF][N_STAGE-1-gi];
      end
    end

    // Twiddle is applied to the difference path as it leaves the stage's delay line.
    for (gi = 0; gi < N_STAGE - 1; gi++) begin : g_tw
      localparam int TAP = off(gi) + dly(gi);
      localparam logic [FW-1:0] LO_MASK = {FW{1'b1}} >> gi;
      logic [FW-1:0] lo;
      assign lo                 = trk_c_reg[TAP][FW-1:0] & LO_MASK;
      assign tw_en[gi]          = trk_v_reg[TAP] & ~trk_c_reg[TAP][N_STAGE-1-gi];
      assign tw_addr[FW*gi +: FW] = tw_en[gi] ? (lo << gi) : '0;
    end

    for (gi = 0; gi < N_STAGE; gi++) begin : g_idx
      assign out_idx[gi] = trk_v_reg[DEPTH] & trk_c_reg[DEPTH][N_STAGE-1-gi];
    end
  endgenerate

  assign out_valid  = trk_v_reg[DEPTH];
  assign frame_done = trk_v_reg[DEPTH] & (&trk_c_reg[DEPTH]);
  assign frame_err  = err_reg;
  assign busy       = (|trk_v_reg) | (|cnt_reg);

endmodule

// File: tb/tb_fft32_sdf_ctrl.sv
// Self-checking bench for fft32_sdf_ctrl: output scoreboard queue plus a tap-history model
// for stage selects, twiddles, busy and abort pulses.
module tb_fft32_sdf_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  stage_sel;
  logic [3:0]  tw_en;
  logic [15:0] tw_addr;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  fft32_sdf_ctrl #(.N_STAGE(5), .STG_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .stage_sel(stage_sel), .tw_en(tw_en), .tw_addr(tw_addr),
    .out_valid(out_valid), .out_idx(out_idx), .frame_done(frame_done),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int SEL_OFF [5] = '{0, 17, 26, 31, 34};
  localparam int TW_TAP  [4] = '{16, 25, 30, 33};
  localparam int OUT_LAT = 36;

  typedef struct {
    int         cyc;
    logic [4:0] idx;
    logic       done;
  } exp_t;

  exp_t       out_q [$];
  int         cyc = 0;
  bit         hv [0:4095];
  logic [4:0] hc [0:4095];
  int         kill = 0;
  int         err_cyc = -1;
  int         mcnt = 0;
  int         reg_cnt_m = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_done = 0;
  int         n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] bitrev(input logic [4:0] v);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  // Validity of the sample presented k cycles ago, honouring abort/reset clears.
  function automatic bit tv(input int k);
    int t;
    t = cyc - k;
    if (t < 0) return 1'b0;
    if (t < kill && cyc >= kill) return 1'b0;
    return hv[t];
  endfunction

  function automatic logic [4:0] tc(input int k);
    int t;
    t = cyc - k;
    if (t < 0) return 5'd0;
    return hc[t];
  endfunction

  task automatic drive(input bit v);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    reg_cnt_m = mcnt;
    hv[cyc]   = v;
    hc[cyc]   = 5'(mcnt);
    if (v) begin
      e.cyc  = cyc + OUT_LAT;
      e.idx  = bitrev(5'(mcnt));
      e.done = (mcnt == 31);
      out_q.push_back(e);
      mcnt = (mcnt + 1) % 32;
    end else if (mcnt != 0) begin
      err_cyc = cyc + 1;
      kill    = cyc + 1;
      mcnt    = 0;
      while (out_q.size() > 0 && out_q[$].cyc > cyc) void'(out_q.pop_back());
    end
  endtask

  always @(negedge clk) begin
    logic [4:0]  sel_exp;
    logic [3:0]  en_exp;
    logic [15:0] addr_exp;
    logic [4:0]  c;
    bit          busy_exp;
    exp_t        e;
    if (!rst_n) begin
      check("reset_outputs",
            {stage_sel, tw_en, tw_addr, out_valid, out_idx, frame_done, frame_err, busy}, 64'd0);
    end else if (cyc > 0) begin
      sel_exp  = '0;
      en_exp   = '0;
      addr_exp = '0;
      for (int s = 0; s < 5; s++) begin
        c = tc(SEL_OFF[s]);
        sel_exp[s] = tv(SEL_OFF[s]) & c[4-s];
      end
      for (int s = 0; s < 4; s++) begin
        c = tc(TW_TAP[s]);
        en_exp[s] = tv(TW_TAP[s]) & ~c[4-s];
        if (en_exp[s]) addr_exp[4*s +: 4] = 4'(((int'(c) & (15 >> s)) << s) & 15);
      end
      check("stage_sel", stage_sel, sel_exp);
      check("tw_en", tw_en, en_exp);
      check("tw_addr", tw_addr, addr_exp);
      check("frame_err", frame_err, cyc == err_cyc);

      busy_exp = (reg_cnt_m != 0) || (out_q.size() > 0 && out_q[0].cyc - OUT_LAT < cyc);
      check("busy", busy, busy_exp);

      if (out_valid) begin
        if (out_q.size() == 0) begin
          check("out_valid_spurious", out_valid, 1'b0);
        end else begin
          e = out_q.pop_front();
          $display("out cycle=%0d idx=%0d done=%0b", cyc, out_idx, frame_done);
          check("out_latency", cyc, e.cyc);
          check("out_idx", out_idx, e.idx);
          check("frame_done", frame_done, e.done);
        end
      end else begin
        check("idle_idx_done", {out_idx, frame_done}, 6'd0);
        if (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
          check("out_valid_missing", out_valid, 1'b1);
          void'(out_q.pop_front());
        end
      end
      if (frame_done) n_done++;
      if (frame_err) n_err++;
    end
  end

  task automatic frame(input int n);
    repeat (n) drive(1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0);
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(6);

    // single frame, then drain
    frame(32);
    idle(45);
    check("done_count_single", n_done, 1);

    // three back-to-back frames
    frame(96);
    idle(45);
    check("done_count_b2b", n_done, 4);

    // full frame, 5 samples of the next, then an illegal gap
    frame(37);
    idle(1);
    idle(3);
    check("err_count_abort", n_err, 1);
    frame(32);
    idle(45);
    check("done_count_after_abort", n_done, 5);

    // asynchronous reset while stage 2 is busy
    frame(32);
    idle(5);
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    kill      = cyc + 1;
    mcnt      = 0;
    reg_cnt_m = 0;
    hv[cyc]   = 1'b0;
    out_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(2);
    frame(32);
    idle(45);
    check("done_count_after_reset", n_done, 6);
    check("err_count_after_reset", n_err, 1);

    // frame, legal 7-cycle gap, frame
    frame(32);
    idle(7);
    frame(32);
    idle(45);
    check("done_count_gap", n_done, 8);
    check("err_count_gap", n_err, 1);
    check("scoreboard_empty", out_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
